// File: rtl/imm_decode_pkg.sv
// Shared constants for the decode-stage immediate generator: RV base opcodes
// and the immediate format code carried with every decoded entry.
package imm_decode_pkg;

   localparam int FMT_W = 3;

   localparam logic [6:0] OPC_LUI     = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
   localparam logic [6:0] OPC_JAL     = 7'b1101111;
   localparam logic [6:0] OPC_JALR    = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
   localparam logic [6:0] OPC_LOAD    = 7'b0000011;
   localparam logic [6:0] OPC_STORE   = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
   localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
   localparam logic [6:0] OPC_OP      = 7'b0110011;
   localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

   typedef enum logic [FMT_W-1:0] {
      FMT_R     = 3'd0,
      FMT_I     = 3'd1,
      FMT_S     = 3'd2,
      FMT_B     = 3'd3,
      FMT_U     = 3'd4,
      FMT_J     = 3'd5,
      FMT_SHIFT = 3'd6,
      FMT_NONE  = 3'd7
   } imm_fmt_e;

endpackage

// File: rtl/imm_extract.sv
// Combinational instruction -> {imm, fmt, illegal} decoder.
// Optional macro IMMDEC_ILLEGAL_CHECK_EN enables the illegal-encoding flag;
// without it the flag is tied low and no check logic exists.
module imm_extract
   import imm_decode_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     inst,
   output logic [XLEN-1:0] imm,
   output imm_fmt_e        fmt,
   output logic            illegal
);

   logic [6:0]  opc;
   logic [2:0]  f3;
   logic [31:0] raw;
   logic        sext;
   logic        is_sh_f3;

   assign opc      = inst[6:0];
   assign f3       = inst[14:12];
   assign is_sh_f3 = (f3 == 3'b001) || (f3 == 3'b101);

   // Pick the format and assemble the 32-bit immediate field before widening
   always_comb begin
      fmt  = FMT_NONE;
      raw  = 32'd0;
      sext = 1'b1;
      case (opc)
         OPC_LUI, OPC_AUIPC: begin
            fmt = FMT_U;
            raw = {inst[31:12], 12'b0};
         end
         OPC_JAL: begin
            fmt = FMT_J;
            raw = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         end
         OPC_JALR, OPC_LOAD, OPC_MISCMEM, OPC_SYSTEM: begin
            fmt = FMT_I;
            raw = {{20{inst[31]}}, inst[31:20]};
         end
         OPC_STORE: begin
            fmt = FMT_S;
            raw = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         end
         OPC_BRANCH: begin
            fmt = FMT_B;
            raw = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         end
         OPC_OPIMM: begin
            if (is_sh_f3) begin
               fmt  = FMT_SHIFT;
               sext = 1'b0;
               raw  = (XLEN == 64) ? {26'd0, inst[25:20]} : {27'd0, inst[24:20]};
            end else begin
               fmt = FMT_I;
               raw = {{20{inst[31]}}, inst[31:20]};
            end
         end
         OPC_OPIMM32: begin
            // word-sized ops only exist on RV64; on RV32 this opcode stays NONE
            if (XLEN == 64) begin
               if (is_sh_f3) begin
                  fmt  = FMT_SHIFT;
                  sext = 1'b0;
                  raw  = {27'd0, inst[24:20]};
               end else begin
                  fmt = FMT_I;
                  raw = {{20{inst[31]}}, inst[31:20]};
               end
            end
         end
         OPC_OP: fmt = FMT_R;
         default: ;
      endcase
   end

   assign imm = sext ? XLEN'($signed(raw)) : XLEN'(raw);

`ifdef IMMDEC_ILLEGAL_CHECK_EN
   logic sh_bad;
   assign sh_bad  = (fmt == FMT_SHIFT) &&
                    (((inst[31:26] != 6'b000000) && (inst[31:26] != 6'b010000)) ||
                     ((XLEN == 32) && inst[25]));
   assign illegal = (inst[1:0] != 2'b11) || (fmt == FMT_NONE) || sh_bad;
`else
   assign illegal = 1'b0;
`endif

endmodule

// File: rtl/imm_decode_stage.sv
// Registered decode-stage immediate generator with a 2-entry skid buffer so
// in_ready is a flop and never depends combinationally on out_ready.
// Optional macro IMMDEC_ILLEGAL_CHECK_EN drives out_illegal (else tied 0).
module imm_decode_stage
   import imm_decode_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_inst,
   input  logic [XLEN-1:0]  in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_inst,
   output logic [XLEN-1:0]  out_pc,
   output logic [XLEN-1:0]  out_imm,
   output logic [FMT_W-1:0] out_fmt,
   output logic             out_illegal
);

   logic [XLEN-1:0] dec_imm;
   imm_fmt_e        dec_fmt;
   logic            dec_ill;

   imm_extract #(.XLEN(XLEN)) u_extract (
      .inst    (in_inst),
      .imm     (dec_imm),
      .fmt     (dec_fmt),
      .illegal (dec_ill)
   );

   logic            main_v_q, main_v_d, skid_v_q, skid_v_d, in_ready_q, in_ready_d;
   logic [31:0]     main_inst_q, main_inst_d, skid_inst_q, skid_inst_d;
   logic [XLEN-1:0] main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
   logic [XLEN-1:0] main_imm_q, main_imm_d, skid_imm_q, skid_imm_d;
   imm_fmt_e        main_fmt_q, main_fmt_d, skid_fmt_q, skid_fmt_d;
   logic            main_ill_q, main_ill_d, skid_ill_q, skid_ill_d;
   logic            accept;

   // in_ready_q is low exactly when both slots are full, so no extra gating
   assign accept = in_valid && in_ready_q;

   // Buffer next-state: EMPTY/ONE/TWO encoded by {skid_v, main_v}; flush wins
   always_comb begin
      main_v_d    = main_v_q;
      skid_v_d    = skid_v_q;
      main_inst_d = main_inst_q;
      main_pc_d   = main_pc_q;
      main_imm_d  = main_imm_q;
      main_fmt_d  = main_fmt_q;
      main_ill_d  = main_ill_q;
      skid_inst_d = skid_inst_q;
      skid_pc_d   = skid_pc_q;
      skid_imm_d  = skid_imm_q;
      skid_fmt_d  = skid_fmt_q;
      skid_ill_d  = skid_ill_q;
      if (flush) begin
         main_v_d = 1'b0;
         skid_v_d = 1'b0;
      end else if (!main_v_q) begin
         if (accept) begin
            main_v_d    = 1'b1;
            main_inst_d = in_inst;
            main_pc_d   = in_pc;
            main_imm_d  = dec_imm;
            main_fmt_d  = dec_fmt;
            main_ill_d  = dec_ill;
         end
      end else if (!skid_v_q) begin
         if (accept && out_ready) begin
            main_inst_d = in_inst;
            main_pc_d   = in_pc;
            main_imm_d  = dec_imm;
            main_fmt_d  = dec_fmt;
            main_ill_d  = dec_ill;
         end else if (accept) begin
            skid_v_d    = 1'b1;
            skid_inst_d = in_inst;
            skid_pc_d   = in_pc;
            skid_imm_d  = dec_imm;
            skid_fmt_d  = dec_fmt;
            skid_ill_d  = dec_ill;
         end else if (out_ready) begin
            main_v_d = 1'b0;
         end
      end else if (out_ready) begin
         // older skid entry moves up; nothing can be accepted while full
         main_v_d    = 1'b1;
         skid_v_d    = 1'b0;
         main_inst_d = skid_inst_q;
         main_pc_d   = skid_pc_q;
         main_imm_d  = skid_imm_q;
         main_fmt_d  = skid_fmt_q;
         main_ill_d  = skid_ill_q;
      end
      in_ready_d = !(main_v_d && skid_v_d);
   end

   // State and data registers, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         main_v_q    <= 1'b0;
         skid_v_q    <= 1'b0;
         in_ready_q  <= 1'b1;
         main_inst_q <= '0;
         main_pc_q   <= '0;
         main_imm_q  <= '0;
         main_fmt_q  <= FMT_R;
         main_ill_q  <= 1'b0;
         skid_inst_q <= '0;
         skid_pc_q   <= '0;
         skid_imm_q  <= '0;
         skid_fmt_q  <= FMT_R;
         skid_ill_q  <= 1'b0;
      end else begin
         main_v_q    <= main_v_d;
         skid_v_q    <= skid_v_d;
         in_ready_q  <= in_ready_d;
         main_inst_q <= main_inst_d;
         main_pc_q   <= main_pc_d;
         main_imm_q  <= main_imm_d;
         main_fmt_q  <= main_fmt_d;
         main_ill_q  <= main_ill_d;
         skid_inst_q <= skid_inst_d;
         skid_pc_q   <= skid_pc_d;
         skid_imm_q  <= skid_imm_d;
         skid_fmt_q  <= skid_fmt_d;
         skid_ill_q  <= skid_ill_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = main_v_q;
   assign out_inst    = main_inst_q;
   assign out_pc      = main_pc_q;
   assign out_imm     = main_imm_q;
   assign out_fmt     = main_fmt_q;
   assign out_illegal = main_ill_q;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: an RV32 and an RV64 instance share the
// same stimulus; expected entries queue on accept and are checked on delivery.
module tb_imm_decode_stage;

`ifdef IMMDEC_ILLEGAL_CHECK_EN
   localparam logic CHK = 1'b1;
`else
   localparam logic CHK = 1'b0;
`endif

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [31:0] imm;
      logic [2:0]  fmt;
      logic        ill;
      logic [63:0] imm64;
      logic        ill64;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, out_ready;
   logic [31:0] in_inst, in_pc;
   logic [63:0] in_pc64;
   logic        in_ready, out_valid, out_illegal;
   logic [31:0] out_inst, out_pc, out_imm;
   logic [2:0]  out_fmt;
   logic        in_ready64, out_valid64, out_illegal64;
   logic [31:0] out_inst64;
   logic [63:0] out_pc64, out_imm64;
   logic [2:0]  out_fmt64;

   exp_t sb[$];
   exp_t cur;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;
   assign in_pc64 = {32'h0, in_pc};

   imm_decode_stage #(.XLEN(32)) u_dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
      .out_inst(out_inst), .out_pc(out_pc), .out_imm(out_imm), .out_fmt(out_fmt),
      .out_illegal(out_illegal)
   );

   imm_decode_stage #(.XLEN(64)) u_dut64 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
      .in_inst(in_inst), .in_pc(in_pc64), .out_valid(out_valid64), .out_ready(out_ready),
      .out_inst(out_inst64), .out_pc(out_pc64), .out_imm(out_imm64), .out_fmt(out_fmt64),
      .out_illegal(out_illegal64)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] imm,
                        input logic [2:0] fmt, input logic ill, input logic [63:0] imm64,
                        input logic ill64);
      in_valid  = 1'b1;
      in_inst   = inst;
      in_pc     = pc;
      cur.inst  = inst;
      cur.pc    = pc;
      cur.imm   = imm;
      cur.fmt   = fmt;
      cur.ill   = ill & CHK;
      cur.imm64 = imm64;
      cur.ill64 = ill64 & CHK;
   endtask

   // Observe handshakes mid-cycle, then advance to just after the next edge
   task automatic tick();
      exp_t e;
      @(negedge clk);
      if (!rst_n) begin
         sb.delete();
      end else begin
         if (out_valid && out_ready) begin
            n_cmp++;
            assert (sb.size() > 0) else begin
               n_err++;
               $error("FAIL unexpected_output observed_inst=0x%0h expected=none", out_inst);
            end
            if (sb.size() > 0) begin
               e = sb.pop_front();
               chk("inst",    {32'h0, out_inst},   {32'h0, e.inst});
               chk("pc",      {32'h0, out_pc},     {32'h0, e.pc});
               chk("imm",     {32'h0, out_imm},    {32'h0, e.imm});
               chk("fmt",     {61'h0, out_fmt},    {61'h0, e.fmt});
               chk("illegal", {63'h0, out_illegal}, {63'h0, e.ill});
               chk("v64",     {63'h0, out_valid64}, 64'h1);
               chk("inst64",  {32'h0, out_inst64}, {32'h0, e.inst});
               chk("pc64",    out_pc64,            {32'h0, e.pc});
               chk("imm64",   out_imm64,           e.imm64);
               chk("fmt64",   {61'h0, out_fmt64},  {61'h0, e.fmt});
               chk("ill64",   {63'h0, out_illegal64}, {63'h0, e.ill64});
            end
         end
         if (flush) sb.delete();
         else if (in_valid && in_ready) sb.push_back(cur);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_inst = '0; in_pc = '0;
      cur = '{inst: 32'h0, pc: 32'h0, imm: 32'h0, fmt: 3'd0, ill: 1'b0, imm64: 64'h0, ill64: 1'b0};

      // reset state
      tick(); tick();
      chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
      chk("rst_in_ready",  {63'h0, in_ready},  64'h1);
      chk("rst_imm",       {32'h0, out_imm},   64'h0);
      chk("rst_inst",      {32'h0, out_inst},  64'h0);
      chk("rst_pc",        {32'h0, out_pc},    64'h0);
      chk("rst_ready64",   {63'h0, in_ready64}, 64'h1);

      // single addi, 1-cycle latency from empty
      rst_n = 1'b1; out_ready = 1'b1;
      drive(32'hFFF00093, 32'h1000, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFF_FFFFFFFF, 1'b0);
      tick(); in_valid = 1'b0;
      chk("lat1_valid", {63'h0, out_valid}, 64'h1);
      chk("lat1_pc",    {32'h0, out_pc},    64'h1000);
      tick();
      chk("idle_valid", {63'h0, out_valid}, 64'h0);

      // back-to-back stream covering every format
      drive(32'h4032D293, 32'h1004, 32'h00000003, 3'd6, 1'b0, 64'h3, 1'b0); tick();
      drive(32'hFE000EE3, 32'h1008, 32'hFFFFFFFC, 3'd3, 1'b0, 64'hFFFFFFFF_FFFFFFFC, 1'b0); tick();
      drive(32'h123450B7, 32'h100C, 32'h12345000, 3'd4, 1'b0, 64'h12345000, 1'b0); tick();
      drive(32'h8000006F, 32'h1010, 32'hFFF00000, 3'd5, 1'b0, 64'hFFFFFFFF_FFF00000, 1'b0); tick();
      drive(32'h00112423, 32'h1014, 32'h00000008, 3'd2, 1'b0, 64'h8, 1'b0); tick();
      drive(32'h002081B3, 32'h1018, 32'h00000000, 3'd0, 1'b0, 64'h0, 1'b0); tick();
      drive(32'h0000007F, 32'h101C, 32'h00000000, 3'd7, 1'b1, 64'h0, 1'b1); tick();
      drive(32'h03F09093, 32'h1020, 32'h0000001F, 3'd6, 1'b1, 64'h3F, 1'b0); tick();
      in_valid = 1'b0; tick(); tick();

      // backpressure: two accepted, third stalls, then in-order drain
      out_ready = 1'b0;
      drive(32'h00001037, 32'h2000, 32'h00001000, 3'd4, 1'b0, 64'h1000, 1'b0); tick();
      chk("bp_ready_one", {63'h0, in_ready}, 64'h1);
      drive(32'h00100013, 32'h2004, 32'h00000001, 3'd1, 1'b0, 64'h1, 1'b0); tick();
      chk("bp_ready_two", {63'h0, in_ready},  64'h0);
      chk("bp_ready64",   {63'h0, in_ready64}, 64'h0);
      chk("bp_hold_a",    {32'h0, out_inst},  64'h00001037);
      drive(32'h00200013, 32'h2008, 32'h00000002, 3'd1, 1'b0, 64'h2, 1'b0); tick();
      chk("bp_stall_ready", {63'h0, in_ready}, 64'h0);
      chk("bp_hold_a2",     {32'h0, out_inst}, 64'h00001037);
      out_ready = 1'b1; tick();
      chk("bp_next_b", {32'h0, out_inst}, 64'h00100013);
      tick(); in_valid = 1'b0; tick();
      chk("bp_drain_ready", {63'h0, in_ready},  64'h1);
      chk("bp_drain_valid", {63'h0, out_valid}, 64'h0);
      chk("bp_sb_empty",    sb.size(),          64'h0);

      // flush while full, with a concurrent in_valid
      out_ready = 1'b0;
      drive(32'h00500013, 32'h3000, 32'h5, 3'd1, 1'b0, 64'h5, 1'b0); tick();
      drive(32'h00600013, 32'h3004, 32'h6, 3'd1, 1'b0, 64'h6, 1'b0); tick();
      chk("fl_full_ready", {63'h0, in_ready}, 64'h0);
      flush = 1'b1;
      drive(32'h00300013, 32'h3008, 32'h3, 3'd1, 1'b0, 64'h3, 1'b0); tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("fl_valid", {63'h0, out_valid}, 64'h0);
      chk("fl_ready", {63'h0, in_ready},  64'h1);

      // flush in ONE with an accept in the same cycle: accept dropped
      drive(32'h00700013, 32'h300C, 32'h7, 3'd1, 1'b0, 64'h7, 1'b0); tick();
      flush = 1'b1;
      drive(32'h00800013, 32'h3010, 32'h8, 3'd1, 1'b0, 64'h8, 1'b0); tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("fl1_valid", {63'h0, out_valid}, 64'h0);
      out_ready = 1'b1; tick(); tick();
      chk("fl_quiet_valid", {63'h0, out_valid}, 64'h0);

      // reset while full, then a fresh accept with 1-cycle latency
      out_ready = 1'b0;
      drive(32'h00900013, 32'h4000, 32'h9, 3'd1, 1'b0, 64'h9, 1'b0); tick();
      drive(32'h00A00013, 32'h4004, 32'hA, 3'd1, 1'b0, 64'hA, 1'b0); tick();
      in_valid = 1'b0; rst_n = 1'b0; tick(); rst_n = 1'b1;
      chk("rst2_valid", {63'h0, out_valid}, 64'h0);
      chk("rst2_ready", {63'h0, in_ready},  64'h1);
      out_ready = 1'b1;
      drive(32'h00400013, 32'h4008, 32'h4, 3'd1, 1'b0, 64'h4, 1'b0); tick();
      in_valid = 1'b0;
      chk("rst2_lat1", {63'h0, out_valid}, 64'h1);
      tick();
      chk("rst2_done", {63'h0, out_valid}, 64'h0);
      chk("final_sb_empty", sb.size(), 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/imm_decode_stage.md
Name: imm_decode_stage

Overview:
- Registered, parametrised immediate generator for the RV pipeline decode stage.
- Accepts fetched instructions over a valid/ready handshake and classifies the encoding format.
- Produces the sign- or zero-extended immediate at XLEN, then presents inst, pc, imm and format one cycle later.
- A 2-entry skid buffer keeps in_ready a registered signal, so downstream stalls never create a combinational ready path back to fetch.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64; sets imm and pc width and shamt width.
FMT_W, 3, width of the format code; fixed, exposed for the package.

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, synchronous, active-low
flush  in  1  synchronous kill of all buffered entries (branch mispredict / hazard squash)
in_valid  in  1  upstream has an instruction
in_ready  out  1  stage can accept; registered
in_inst  in  32  instruction word
in_pc  in  XLEN  instruction address
out_valid  out  1  output entry valid
out_ready  in  1  downstream accepts
out_inst  out  32  passthrough instruction
out_pc  out  XLEN  passthrough pc
out_imm  out  XLEN  decoded immediate
out_fmt  out  3  format code
out_illegal  out  1  illegal-encoding flag; constant 0 when the optional feature is absent

Behaviour:
- Reset values, on a clk edge with rst_n=0: out_valid=0, in_ready=1, skid_valid=0. Data registers are cleared to 0.
- Reset mid-transfer discards both entries, with no partial output.
- Handshakes:
  - Transfer in on in_valid&&in_ready; transfer out on out_valid&&out_ready.
  - Latency is exactly 1 cycle from accept to out_valid when the stage is empty.
  - Output data is held stable while out_valid&&!out_ready.
- Buffer states:
  - EMPTY: out_valid=0, skid=0.
  - ONE: main entry valid, skid empty.
  - TWO: main and skid both valid; in_ready=0.
- State transitions:
  - EMPTY + accept -> ONE.
  - ONE + accept + !out_ready -> TWO, with the new entry in skid.
  - ONE + accept + out_ready -> ONE, with main replaced by the new entry.
  - ONE + !accept + out_ready -> EMPTY.
  - TWO + out_ready -> ONE, with skid moved to main.
  - in_ready next = !(next state == TWO).
- Ordering: strictly in order. The skid entry is never presented before the main entry.
- Flush:
  - On the next edge, the state goes to EMPTY and in_ready=1.
  - An accept in the same cycle as flush is dropped.
  - Flush has priority over every other transition. rst_n has priority over flush.
- Decode is combinational on the input and registered with the entry. Imm is sign-extended from bit 31 to XLEN unless noted.
- Format codes: R=0, I=1, S=2, B=3, U=4, J=5, SHIFT=6, NONE=7.
- Opcode mapping:
  - 0110111 LUI and 0010111 AUIPC -> U: {inst[31:12],12'b0}.
  - 1101111 -> J: {inst[31],inst[19:12],inst[20],inst[30:21],0}.
  - 1100111 JALR, 0000011 LOAD, 0001111 MISC-MEM, 1110011 SYSTEM -> I: inst[31:20].
  - 0100011 -> S: {inst[31:25],inst[11:7]}.
  - 1100011 -> B: {inst[31],inst[7],inst[30:25],inst[11:8],0}.
  - 0010011 with funct3 001/101 -> SHIFT, zero-extended shamt:
    - inst[24:20] when XLEN=32.
    - inst[25:20] when XLEN=64.
  - 0010011 with other funct3 -> I.
  - 0011011 (XLEN=64 only) -> SHIFT with inst[24:20] for funct3 001/101, else I.
  - 0110011 OP -> R, imm=0.
  - Any other opcode, including 0011011 when XLEN=32 -> NONE, imm=0.
- funct3 comparisons are 3-bit binary literals.

Optional Feature:
- Macro: IMMDEC_ILLEGAL_CHECK_EN.
- When defined, out_illegal=1 for any of:
  - inst[1:0]!=2'b11.
  - fmt NONE.
  - SHIFT with inst[31:26] not 000000/010000.
  - SHIFT with XLEN=32 and inst[25]=1.
  - The flag travels with its entry; imm and fmt are still produced as above.
- When not defined, out_illegal is tied 0 and the check logic is not compiled.

Decomposition:
- Package imm_decode_pkg holds:
  - Opcode constants (OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OPIMM32, OPC_OP, OPC_MISCMEM, OPC_SYSTEM).
  - The imm_fmt_e enum (FMT_R..FMT_NONE) and FMT_W.
- One sub-module, imm_extract: a purely combinational inst -> {imm,fmt,illegal} function parametrised by XLEN.
- The top level holds the skid buffer and the flush/reset control.

Test Plan:
- XLEN=32, addi 0xFFF00093 with out_ready=1 -> next cycle out_valid=1, imm=0xFFFFFFFF, fmt=1, pc passed through unchanged.
- srai 0x4032D293 -> imm=0x00000003, fmt=6 (not 0x403). beq 0xFE000EE3 -> imm=0xFFFFFFFC, fmt=3. lui 0x123450B7 -> imm=0x12345000, fmt=4.
- out_ready=0 while 3 back-to-back in_valid -> 2 accepted, in_ready=0 on the third. Release out_ready -> outputs delivered in order, no loss or duplication, in_ready returns to 1.
- State TWO, then flush=1 together with in_valid=1 -> next cycle out_valid=0, in_ready=1, and no flushed or concurrent entry ever appears at the output.
- rst_n=0 for one edge while in state TWO -> out_valid=0, in_ready=1; a later accept appears after exactly 1 cycle.
- XLEN=64, slli 0x03F09093 -> imm=0x3F. With IMMDEC_ILLEGAL_CHECK_EN, XLEN=32: the same inst gives out_illegal=1, and opcode 0x0000007F gives fmt=7, illegal=1.
